// File: rtl/mux_rr_arbiter_if.sv
// Bundle between four producers, the round-robin arbiter and one downstream consumer.
// The arbiter takes the slave modport; the producers/consumer side takes the master modport.
interface mux_rr_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]    req;
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic [DW-1:0] in3;
    logic [DW-1:0] in4;
    logic          out_ready;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] out1;
    logic          out1_valid;

    modport master (
        output req, in1, in2, in3, in4, out_ready,
        input  gnt, sel, out1, out1_valid
    );

    modport slave (
        input  req, in1, in2, in3, in4, out_ready,
        output gnt, sel, out1, out1_valid
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin 4:1 arbiter with burst limit and an internal 2:1-tree data mux.
// Define MUX_ARB_OUT_REG_EN to register out1/out1_valid (1-cycle data latency, full throughput).
module mux_rr_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_rr_arbiter_if.slave bus
);

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("mux_rr_arbiter: MAX_BURST must be within 1..15");
    end

    localparam logic [3:0] BURST_LEN = 4'(MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] cnt_q, cnt_d;

    logic [DW-1:0] mux_lo;
    logic [DW-1:0] mux_hi;
    logic [DW-1:0] mux_out;
    logic          req_sel;
    logic          granted;
    logic          accept;
    logic          last_beat;
    logic          release_c;
    logic [1:0]    scan_ptr;
    logic [2:0]    pick;

    // Lowest index wins when scanning downward, so offset 0 (the pointer itself) has top priority.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    always_comb begin
        mux_lo  = sel_q[0] ? bus.in2 : bus.in1;
        mux_hi  = sel_q[0] ? bus.in4 : bus.in3;
        mux_out = sel_q[1] ? mux_hi : mux_lo;
        req_sel = bus.req[sel_q];
        granted = |gnt_q;
    end

`ifdef MUX_ARB_OUT_REG_EN
    logic [DW-1:0] out1_q, out1_d;
    logic          out1_valid_q, out1_valid_d;
    logic          load;

    // Skid-free output stage: refill whenever empty or being drained this cycle.
    always_comb begin
        load         = !out1_valid_q || bus.out_ready;
        accept       = req_sel && granted && load;
        out1_d       = out1_q;
        out1_valid_d = out1_valid_q;
        if (load) begin
            out1_valid_d = accept;
            if (accept) out1_d = mux_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out1_q       <= '0;
            out1_valid_q <= 1'b0;
        end else begin
            out1_q       <= out1_d;
            out1_valid_q <= out1_valid_d;
        end
    end

    assign bus.out1       = out1_q;
    assign bus.out1_valid = out1_valid_q;
`else
    logic out1_valid_c;

    always_comb begin
        out1_valid_c = req_sel && granted;
        accept       = out1_valid_c && bus.out_ready;
    end

    assign bus.out1       = mux_out;
    assign bus.out1_valid = out1_valid_c;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        last_beat = accept && (cnt_q + 4'd1 == BURST_LEN);
        release_c = (state_q == GRANT) && (!req_sel || last_beat);
        // On release the just-served requester drops to lowest priority for the same-cycle re-arbitration.
        scan_ptr  = release_c ? sel_q + 2'd1 : ptr_q;
        pick      = rr_pick(bus.req, scan_ptr);

        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (pick[2]) begin
                    gnt_d   = onehot4(pick[1:0]);
                    sel_d   = pick[1:0];
                    cnt_d   = 4'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_d = scan_ptr;
                    cnt_d = 4'd0;
                    if (pick[2]) begin
                        gnt_d = onehot4(pick[1:0]);
                        sel_d = pick[1:0];
                    end else begin
                        gnt_d   = 4'b0000;
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt = gnt_q;
    assign bus.sel = sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=2.
// Expected values follow the combinational or registered output mode selected by MUX_ARB_OUT_REG_EN.
module tb_mux_rr_arbiter;

`ifdef MUX_ARB_OUT_REG_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.DW(8)) b4 ();
    mux_rr_arbiter_if #(.DW(8)) b2 ();

    mux_rr_arbiter #(.DW(8), .MAX_BURST(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    mux_rr_arbiter #(.DW(8), .MAX_BURST(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] d2 [4];
    int   sent;
    int   rx;
    logic acc;

    initial begin
        rst_n        = 1'b0;
        b4.req       = 4'b0000;
        b4.in1       = 8'hA5;
        b4.in2       = 8'h00;
        b4.in3       = 8'h00;
        b4.in4       = 8'h00;
        b4.out_ready = 1'b0;
        b2.req       = 4'b0000;
        b2.in1       = 8'h10;
        b2.in2       = 8'h20;
        b2.in3       = 8'h30;
        b2.in4       = 8'h40;
        b2.out_ready = 1'b0;
        d2[0] = 8'h10; d2[1] = 8'h20; d2[2] = 8'h30; d2[3] = 8'h40;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_gnt",   32'(b4.gnt), 0);
        chk("rst_sel",   32'(b4.sel), 0);
        chk("rst_vld",   32'(b4.out1_valid), 0);
        chk("rst_out1",  32'(b4.out1), REG ? 0 : 32'hA5);
        chk("rst_gnt2",  32'(b2.gnt), 0);

        // Single requester in2, MAX_BURST=4: re-granted every 4 beats with no bubble
        tick();
        rst_n = 1'b1;
        b4.req = 4'b0010; b4.in2 = 8'd1; b4.out_ready = 1'b1;
        @(negedge clk);
        chk("s1_lat_gnt", 32'(b4.gnt), 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            b4.in2 = 8'(k);
            @(negedge clk);
            chk("s1_gnt",  32'(b4.gnt), 32'h2);
            chk("s1_sel",  32'(b4.sel), 1);
            chk("s1_vld",  32'(b4.out1_valid), (REG && k == 1) ? 0 : 1);
            chk("s1_out1", 32'(b4.out1), REG ? 32'(k - 1) : 32'(k));
        end
        tick();
        b4.req = 4'b0000;
        @(negedge clk);
        chk("s1_tail_vld",  32'(b4.out1_valid), REG ? 1 : 0);
        if (REG) chk("s1_tail_out1", 32'(b4.out1), 8);
        tick();
        @(negedge clk);
        chk("s1_idle_gnt", 32'(b4.gnt), 0);

        // All four requesting, MAX_BURST=2: in1,in2,in3,in4,in1 with two beats each
        tick();
        b2.req = 4'b1111; b2.out_ready = 1'b1;
        @(negedge clk);
        chk("s2_lat_gnt", 32'(b2.gnt), 0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            @(negedge clk);
            chk("s2_gnt",  32'(b2.gnt), 32'(1 << (((c - 1) / 2) % 4)));
            chk("s2_sel",  32'(b2.sel), 32'(((c - 1) / 2) % 4));
            chk("s2_vld",  32'(b2.out1_valid), (REG && c == 1) ? 0 : 1);
            chk("s2_out1", 32'(b2.out1),
                REG ? ((c >= 2) ? 32'(d2[((c - 2) / 2) % 4]) : 0) : 32'(d2[((c - 1) / 2) % 4]));
        end
        tick();
        b2.req = 4'b0000;
        tick();
        @(negedge clk);
        chk("s2_idle_gnt", 32'(b2.gnt), 0);

        // Backpressure on in3 (in4 also waiting): count frozen, burst completes after ready returns
        tick();
        b4.req = 4'b1100; b4.in3 = 8'h31; b4.in4 = 8'h41; b4.out_ready = 1'b1;
        @(negedge clk);
        chk("s3_lat_gnt", 32'(b4.gnt), 0);
        tick();
        @(negedge clk);
        chk("s3_c1_gnt",  32'(b4.gnt), 32'h4);
        chk("s3_c1_vld",  32'(b4.out1_valid), REG ? 0 : 1);
        if (!REG) chk("s3_c1_out1", 32'(b4.out1), 32'h31);
        tick();
        b4.in3 = 8'h32; b4.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) tick();
            @(negedge clk);
            chk("s3_stall_gnt",  32'(b4.gnt), 32'h4);
            chk("s3_stall_out1", 32'(b4.out1), REG ? 32'h31 : 32'h32);
            chk("s3_stall_vld",  32'(b4.out1_valid), 1);
        end
        tick();
        b4.out_ready = 1'b1;
        @(negedge clk);
        chk("s3_c5_gnt",  32'(b4.gnt), 32'h4);
        chk("s3_c5_out1", 32'(b4.out1), REG ? 32'h31 : 32'h32);
        tick();
        b4.in3 = 8'h33;
        @(negedge clk);
        chk("s3_c6_gnt",  32'(b4.gnt), 32'h4);
        chk("s3_c6_out1", 32'(b4.out1), REG ? 32'h32 : 32'h33);
        tick();
        b4.in3 = 8'h34;
        @(negedge clk);
        chk("s3_c7_gnt",  32'(b4.gnt), 32'h4);
        chk("s3_c7_out1", 32'(b4.out1), REG ? 32'h33 : 32'h34);
        tick();
        b4.req = 4'b0000;
        @(negedge clk);
        chk("s3_hand_gnt", 32'(b4.gnt), 32'h8);
        chk("s3_hand_sel", 32'(b4.sel), 3);
        chk("s3_hand_vld", 32'(b4.out1_valid), REG ? 1 : 0);
        if (REG) chk("s3_hand_out1", 32'(b4.out1), 32'h34);
        tick();
        @(negedge clk);
        chk("s3_idle_gnt", 32'(b4.gnt), 0);

        // Early drop: in1 drops after one beat while in4 waits
        tick();
        b4.req = 4'b1001; b4.in1 = 8'h11; b4.in4 = 8'h44;
        @(negedge clk);
        chk("s4_lat_gnt", 32'(b4.gnt), 0);
        tick();
        @(negedge clk);
        chk("s4_c1_gnt", 32'(b4.gnt), 32'h1);
        if (!REG) chk("s4_c1_out1", 32'(b4.out1), 32'h11);
        tick();
        b4.req = 4'b1000;
        @(negedge clk);
        chk("s4_c2_gnt", 32'(b4.gnt), 32'h1);
        chk("s4_c2_vld", 32'(b4.out1_valid), REG ? 1 : 0);
        tick();
        @(negedge clk);
        chk("s4_c3_gnt", 32'(b4.gnt), 32'h8);
        chk("s4_c3_sel", 32'(b4.sel), 3);
        tick();
        b4.req = 4'b0000;
        tick();
        // Second drop: after in1 is released, the scan starts at in2, ahead of in4
        b4.req = 4'b1011;
        @(negedge clk);
        chk("s4b_lat_gnt", 32'(b4.gnt), 0);
        tick();
        @(negedge clk);
        chk("s4b_c1_gnt", 32'(b4.gnt), 32'h1);
        tick();
        b4.req = 4'b1010;
        tick();
        @(negedge clk);
        chk("s4b_c3_gnt", 32'(b4.gnt), 32'h2);
        chk("s4b_c3_sel", 32'(b4.sel), 1);
        tick();
        b4.req = 4'b0000;
        tick();
        @(negedge clk);
        chk("s4b_idle_gnt", 32'(b4.gnt), 0);

        // Reset mid-burst with in2 granted and two beats taken
        tick();
        b4.req = 4'b0010; b4.in2 = 8'h21;
        tick();
        @(negedge clk);
        chk("s5_c1_gnt", 32'(b4.gnt), 32'h2);
        tick();
        b4.in2 = 8'h22;
        tick();
        b4.in2 = 8'h23; rst_n = 1'b0;
        @(negedge clk);
        chk("s5_c3_gnt", 32'(b4.gnt), 32'h2);
        tick();
        rst_n = 1'b1;
        b4.req = 4'b1111; b4.in1 = 8'h51; b4.in2 = 8'h52; b4.in3 = 8'h53; b4.in4 = 8'h54;
        @(negedge clk);
        chk("s5_rst_gnt",  32'(b4.gnt), 0);
        chk("s5_rst_sel",  32'(b4.sel), 0);
        chk("s5_rst_vld",  32'(b4.out1_valid), 0);
        chk("s5_rst_out1", 32'(b4.out1), REG ? 0 : 32'h51);
        tick();
        @(negedge clk);
        chk("s5_post_gnt", 32'(b4.gnt), 32'h1);
        chk("s5_post_sel", 32'(b4.sel), 0);
        tick();
        b4.req = 4'b0000;
        tick();
        @(negedge clk);
        chk("s5_idle_gnt", 32'(b4.gnt), 0);

        // Six beats from in2 with out_ready toggling 1,0,1,0: none lost, none duplicated
        tick();
        sent = 0; rx = 0;
        b4.req = 4'b0010; b4.in2 = 8'h80; b4.out_ready = 1'b1;
        for (int t = 0; t < 60 && rx < 6; t++) begin
            @(negedge clk);
            acc = b4.gnt[1] && b4.req[1] && (REG ? (!b4.out1_valid || b4.out_ready) : b4.out_ready);
            if (b4.out1_valid && b4.out_ready) begin
                chk("s6_rx_data", 32'(b4.out1), 32'(8'h80 + rx));
                rx++;
            end
            tick();
            if (acc) begin
                sent++;
                if (sent == 6) b4.req = 4'b0000;
                else           b4.in2 = 8'(8'h80 + sent);
            end
            b4.out_ready = ~b4.out_ready;
        end
        chk("s6_rx_count",   32'(rx), 6);
        chk("s6_sent_count", 32'(sent), 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 data mux built from 2:1 stages. It shares a single output channel between four requesters with a valid/ready handshake. It registers one-hot grants and drives the mux select. It bounds each grant to a burst of at most MAX_BURST beats so that no requester can starve the others. The block sits between four producers and one downstream consumer and contains the mux datapath internally.

## Interface
- DW, 8, data width of each input and of out1
- MAX_BURST, 4, maximum beats per grant; legal range 1..15; beat counter is 4 bits
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  4  per-requester valid; req[0..3] belong to in1..in4; a requester holds req and data stable until its beat is accepted
- in1, in2, in3, in4  in  DW each  requester data
- out_ready  in  1  downstream ready
- gnt  out  4  registered grant, one-hot or zero; doubles as per-requester ready qualifier
- sel  out  2  registered mux select; 0→in1, 1→in2, 2→in3, 3→in4
- out1  out  DW  muxed data
- out1_valid  out  1  muxed valid

## Operation
- State: FSM {IDLE, GRANT}, ptr[1:0] (highest-priority index), cnt[3:0] (beats this grant).
- IDLE: gnt=0, out1_valid=0. If req≠0, choose the first set bit scanning ptr, ptr+1, … mod 4. Load gnt/sel with it, clear cnt, go to GRANT.
- GRANT: requester sel owns the channel. A beat is accepted when req[sel] is high and the accept condition holds (see Configuration). Each accepted beat does cnt+1.
- Release occurs in the cycle that either of the following holds:
  - req[sel] is low;
  - a beat is accepted and cnt+1 == MAX_BURST.
- On release: ptr ← sel+1 mod 4, and re-arbitrate in the same cycle over current req, scanning from the new ptr. The released requester therefore has lowest priority but may be regranted if it is the only one requesting.
  - If a winner exists, load it into gnt/sel with cnt=0 and stay in GRANT. There is no idle bubble.
  - Otherwise gnt=0 and go to IDLE.
- A requester dropping req while granted is legal; no beat is taken that cycle.
- req bits of non-granted requesters are ignored until arbitration.
- Unconnected/illegal: MAX_BURST=0 or >15 is not supported.
- Reset (rst_n low at a clock edge, including mid-burst) has these effects:
  - state=IDLE, gnt=0, sel=0, ptr=0, cnt=0, out1_valid=0;
  - out1 reads 0 in registered mode and in1 data in combinational mode;
  - any beat presented in that cycle is dropped.

## Timing
- Arbitration latency: req rising in cycle N while IDLE → gnt valid in cycle N+1.
- Handover: release in cycle N → next grant visible in cycle N+1. Back-to-back bursts can therefore sustain 1 beat/cycle.
- Combinational mode: out1 = in[sel], out1_valid = req[sel] & |gnt, and accept = out1_valid & out_ready. The path from req/in to out1 and out_ready to accept has zero latency.
- gnt and sel never change except at a clock edge.

## Configuration
- MUX_ARB_OUT_REG_EN defined: out1/out1_valid are registered.
  - Output register loads when !out1_valid | out_ready.
  - A beat is accepted when req[sel] & |gnt & load. The register then takes in[sel] and sets out1_valid=1.
  - If load is true but no beat is accepted, out1_valid clears.
  - The register holds data while out1_valid & !out_ready.
  - Data latency is 1 cycle; throughput is still 1 beat/cycle.
- MUX_ARB_OUT_REG_EN undefined: combinational output as in Timing, with no extra latency.

## Test plan
- Single requester: MAX_BURST=4, req=4'b0010 held, out_ready=1, in2 increments 1..8.
  - gnt=0010 from cycle 1; cnt wraps each 4 beats with re-grant to the same requester and no bubble.
  - out1 sequence 1..8 appears contiguously.
- All requesting: req=4'b1111 held, out_ready=1, MAX_BURST=2.
  - Grant order is in1,in2,in3,in4,in1,…, exactly 2 beats each.
  - ptr advances 0→1→2→3→0.
- Backpressure: in3 granted, out_ready low for 3 cycles mid-burst.
  - cnt frozen; out1 holds in3 value; gnt unchanged.
  - Burst completes after out_ready returns.
- Early drop: in1 granted, in1 drops req after 1 beat while in4 requests.
  - gnt→1000 next cycle; ptr=1; next arbitration order is in2,in3,in4,in1.
- Reset mid-burst: rst_n low for one edge while in2 is granted with cnt=2.
  - Next cycle gnt=0, sel=0, out1_valid=0, state IDLE.
  - After release, a req=4'b1111 grant goes to in1.
- MUX_ARB_OUT_REG_EN defined: repeat the single-requester and backpressure scenarios.
  - out1 lags accept by 1 cycle; no beat is lost or duplicated under out_ready toggling 1,0,1,0.
